// File: rtl/fetch_sequencer.sv
// Autonomous instruction-fetch sequencer: T0/T1/T2 fetch, optional indirect cycle, EXEC handover.
// Optional macro INDIRECT_EN adds the IND state (extra memory read for indirect operands).
module fetch_sequencer #(
  parameter int AW   = 12,
  parameter int DW   = 16,
  parameter int SC_W = 3
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic                 start,
  input  logic                 halt,
  output logic [AW-1:0]        mem_addr,
  output logic                 mem_rd,
  input  logic [DW-1:0]        mem_rdata,
  input  logic                 mem_ready,
  input  logic                 pc_ld,
  input  logic [AW-1:0]        pc_din,
  input  logic                 exec_done,
  output logic [AW-1:0]        pc,
  output logic [AW-1:0]        ar,
  output logic [DW-1:0]        ir,
  output logic                 ind,
  output logic [2:0]           opcode,
  output logic [SC_W-1:0]      sc,
  output logic [2**SC_W-1:0]   t_dec,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_IND  = 3'd4,
    S_EXEC = 3'd5
  } state_e;

  localparam logic [AW-1:0]   PC_ONE = AW'(1);
  localparam logic [SC_W-1:0] SC_ONE = SC_W'(1);
  localparam logic [SC_W-1:0] SC_MAX = '1;

  state_e          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [AW-1:0]   ar_q, ar_d;
  logic [DW-1:0]   ir_q, ir_d;
  logic            ind_q, ind_d;
  logic [SC_W-1:0] sc_q, sc_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ar_d    = ar_q;
    ir_d    = ir_q;
    ind_d   = ind_q;
    sc_d    = sc_q;
    case (state_q)
      S_IDLE: begin
        if (start && !halt) state_d = S_T0;
      end
      S_T0: begin
        ar_d    = pc_q;
        sc_d    = '0;
        state_d = S_T1;
      end
      S_T1: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + PC_ONE;
          sc_d    = sc_q + SC_ONE;
          state_d = S_T2;
        end
      end
      S_T2: begin
        ar_d  = ir_q[AW-1:0];
        ind_d = ir_q[DW-1];
        sc_d  = sc_q + SC_ONE;
`ifdef INDIRECT_EN
        // opcode 3'b111 marks register/IO instructions, which never take the indirect cycle
        if (ir_q[DW-1] && (ir_q[DW-2:DW-4] != 3'b111)) state_d = S_IND;
        else                                           state_d = S_EXEC;
`else
        state_d = S_EXEC;
`endif
      end
`ifdef INDIRECT_EN
      S_IND: begin
        if (mem_ready) begin
          ar_d    = mem_rdata[AW-1:0];
          sc_d    = sc_q + SC_ONE;
          state_d = S_EXEC;
        end
      end
`endif
      S_EXEC: begin
        if (sc_q != SC_MAX) sc_d = sc_q + SC_ONE;
        if (pc_ld) pc_d = pc_din;
        if (exec_done) state_d = (halt || !start) ? S_IDLE : S_T0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ar_q    <= '0;
      ir_q    <= '0;
      ind_q   <= 1'b0;
      sc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ar_q    <= ar_d;
      ir_q    <= ir_d;
      ind_q   <= ind_d;
      sc_q    <= sc_d;
    end
  end

  // Read strobe follows the state register so reset drops it without a clock edge
  assign mem_rd   = (state_q == S_T1) || (state_q == S_IND);
  assign mem_addr = ar_q;
  assign pc       = pc_q;
  assign ar       = ar_q;
  assign ir       = ir_q;
  assign ind      = ind_q;
  assign opcode   = ir_q[DW-2:DW-4];
  assign sc       = sc_q;
  assign state    = state_q;

  always_comb begin
    t_dec       = '0;
    t_dec[sc_q] = 1'b1;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized instruction
// streams compared against a per-instruction behavioural model of the fetch rules.
module tb_fetch_sequencer;
  logic        clk = 1'b0;
  logic        clr_n, start, halt, mem_ready, pc_ld, exec_done;
  logic [11:0] pc_din, mem_addr, pc, ar;
  logic [15:0] mem_rdata, ir;
  logic        mem_rd, ind;
  logic [2:0]  opcode, state, sc;
  logic [7:0]  t_dec;

  int errors = 0;
  int checks = 0;
  logic [15:0] mem [0:4095];
  logic [11:0] m_pc;

  fetch_sequencer dut (
    .clk(clk), .clr_n(clr_n), .start(start), .halt(halt),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc_ld(pc_ld), .pc_din(pc_din), .exec_done(exec_done),
    .pc(pc), .ar(ar), .ir(ir), .ind(ind), .opcode(opcode), .sc(sc), .t_dec(t_dec), .state(state)
  );

  always #5 clk = ~clk;

  // Inputs that must be ignored in the current state get random values
  task automatic noise();
    mem_ready = 1'($urandom);
    mem_rdata = 16'($urandom);
    pc_ld     = 1'($urandom);
    pc_din    = 12'($urandom);
    exec_done = 1'($urandom);
  endtask

  // Runs one instruction from T0; model: IR=M[PC], PC+1, AR=effective address, sc counts fetch steps
  task automatic run_instr(input int t1w, input int iw, input int elen, input bit br,
                           input logic [11:0] tgt, input bit halt_mid, input bit stop);
    logic [15:0] e_ir, ptr_word;
    logic [11:0] e_ar;
    logic [2:0]  e_sc, e_next;
    bit          is_ind;
    e_ir   = mem[m_pc];
    is_ind = 1'b0;
`ifdef INDIRECT_EN
    is_ind = e_ir[15] && (e_ir[14:12] != 3'b111);
`endif
    ptr_word = mem[e_ir[11:0]];
    e_ar     = is_ind ? ptr_word[11:0] : e_ir[11:0];

    checks++; if (state !== 3'd1) begin errors++; $display("FAIL t0_state got %0d exp 1", state); end
    noise();
    @(negedge clk);
    checks++; if (state !== 3'd2 || ar !== m_pc || mem_addr !== m_pc || mem_rd !== 1'b1 || sc !== 3'd0) begin
      errors++; $display("FAIL t1_entry state=%0d ar=%h addr=%h rd=%b sc=%0d exp 2/%h/%h/1/0", state, ar, mem_addr, mem_rd, sc, m_pc, m_pc);
    end
    if (halt_mid) halt = 1'b1;
    if (stop) start = 1'b0;
    for (int w = 0; w < t1w; w++) begin
      mem_ready = 1'b0; mem_rdata = 16'($urandom);
      pc_ld = 1'($urandom); pc_din = 12'($urandom); exec_done = 1'($urandom);
      @(negedge clk);
      checks++; if (state !== 3'd2 || sc !== 3'd0 || mem_rd !== 1'b1 || pc !== m_pc) begin
        errors++; $display("FAIL t1_wait state=%0d sc=%0d rd=%b pc=%h exp 2/0/1/%h", state, sc, mem_rd, pc, m_pc);
      end
    end
    mem_ready = 1'b1; mem_rdata = e_ir; pc_ld = 1'b1; pc_din = ~m_pc; exec_done = 1'b1;
    @(negedge clk);
    m_pc = m_pc + 12'd1;
    checks++; if (state !== 3'd3 || ir !== e_ir || pc !== m_pc || sc !== 3'd1 || t_dec !== 8'd2) begin
      errors++; $display("FAIL t2_entry state=%0d ir=%h pc=%h sc=%0d tdec=%b exp 3/%h/%h/1/00000010", state, ir, pc, sc, t_dec, e_ir, m_pc);
    end
    noise();
    @(negedge clk);
    if (is_ind) begin
      checks++; if (state !== 3'd4 || ar !== e_ir[11:0] || mem_rd !== 1'b1 || ind !== 1'b1) begin
        errors++; $display("FAIL ind_entry state=%0d ar=%h rd=%b ind=%b exp 4/%h/1/1", state, ar, mem_rd, ind, e_ir[11:0]);
      end
      for (int w = 0; w < iw; w++) begin
        mem_ready = 1'b0; mem_rdata = 16'($urandom);
        @(negedge clk);
        checks++; if (state !== 3'd4 || sc !== 3'd2) begin
          errors++; $display("FAIL ind_wait state=%0d sc=%0d exp 4/2", state, sc);
        end
      end
      mem_ready = 1'b1; mem_rdata = ptr_word;
      @(negedge clk);
    end
    e_sc = is_ind ? 3'd3 : 3'd2;
    checks++; if (state !== 3'd5 || ar !== e_ar || ind !== e_ir[15] || opcode !== e_ir[14:12] || sc !== e_sc || pc !== m_pc) begin
      errors++; $display("FAIL exec_entry state=%0d ar=%h ind=%b op=%0d sc=%0d pc=%h exp 5/%h/%b/%0d/%0d/%h",
                         state, ar, ind, opcode, sc, pc, e_ar, e_ir[15], e_ir[14:12], e_sc, m_pc);
    end
    for (int c = 1; c <= elen; c++) begin
      mem_ready = 1'($urandom); mem_rdata = 16'($urandom);
      if (c < elen) begin exec_done = 1'b0; pc_ld = 1'b0; end
      else begin exec_done = 1'b1; pc_ld = br; pc_din = tgt; end
      @(negedge clk);
      e_sc = (e_sc == 3'd7) ? 3'd7 : e_sc + 3'd1;
      if (c < elen) begin
        checks++; if (state !== 3'd5 || sc !== e_sc) begin
          errors++; $display("FAIL exec_hold state=%0d sc=%0d exp 5/%0d", state, sc, e_sc);
        end
      end
    end
    exec_done = 1'b0; pc_ld = 1'b0;
    if (br) m_pc = tgt;
    e_next = (halt || !start) ? 3'd0 : 3'd1;
    checks++; if (state !== e_next || pc !== m_pc) begin
      errors++; $display("FAIL exec_exit state=%0d pc=%h exp %0d/%h", state, pc, e_next, m_pc);
    end
  endtask

  task automatic begin_run();
    start = 1'b1; halt = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    clr_n = 1'b0; start = 1'b0; halt = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    pc_ld = 1'b0; pc_din = '0; exec_done = 1'b0;
    #1;
    checks++; if (pc !== 0 || ar !== 0 || ir !== 0 || ind !== 0 || sc !== 0 || mem_rd !== 0 || state !== 0 || t_dec !== 8'd1) begin
      errors++; $display("FAIL reset pc=%h ar=%h ir=%h ind=%b sc=%0d rd=%b state=%0d tdec=%b", pc, ar, ir, ind, sc, mem_rd, state, t_dec);
    end
    @(negedge clk); clr_n = 1'b1;
    noise(); halt = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++; if (state !== 3'd0 || pc !== 12'd0) begin
      errors++; $display("FAIL idle_hold state=%0d pc=%h exp 0/000", state, pc);
    end
    pc_ld = 1'b0; exec_done = 1'b0;
    m_pc = '0;
  endtask

  task automatic test_zero_wait();
    mem[0] = 16'h2005;
    begin_run();
    run_instr(0, 0, 2, 1'b0, 12'h000, 1'b0, 1'b1);
    checks++; if (ir !== 16'h2005 || opcode !== 3'd2 || ind !== 1'b0 || ar !== 12'h005 || pc !== 12'h001) begin
      errors++; $display("FAIL zero_wait ir=%h op=%0d ind=%b ar=%h pc=%h exp 2005/2/0/005/001", ir, opcode, ind, ar, pc);
    end
  endtask

  task automatic test_wait_states();
    mem[1] = 16'h7123;
    begin_run();
    run_instr(3, 0, 1, 1'b0, 12'h000, 1'b0, 1'b1);
    checks++; if (ir !== 16'h7123 || pc !== 12'h002) begin
      errors++; $display("FAIL wait_states ir=%h pc=%h exp 7123/002", ir, pc);
    end
  endtask

  task automatic test_indirect();
    mem[2]  = 16'hA010;
    mem[16] = 16'h0123;
    begin_run();
    run_instr(1, 2, 1, 1'b0, 12'h000, 1'b0, 1'b1);
`ifdef INDIRECT_EN
    checks++; if (ar !== 12'h123) begin errors++; $display("FAIL indirect_ar got %h exp 123", ar); end
`else
    checks++; if (ar !== 12'h010) begin errors++; $display("FAIL direct_ar got %h exp 010", ar); end
`endif
  endtask

  task automatic test_branch();
    begin_run();
    run_instr(0, 0, 3, 1'b1, 12'h3FF, 1'b0, 1'b0);
    run_instr(1, 0, 1, 1'b1, 12'hFFF, 1'b0, 1'b0);
    run_instr(0, 1, 2, 1'b0, 12'h000, 1'b0, 1'b1);
    checks++; if (pc !== 12'h000) begin errors++; $display("FAIL pc_wrap got %h exp 000", pc); end
  endtask

  task automatic test_halt_start();
    begin_run();
    run_instr(2, 0, 2, 1'b0, 12'h000, 1'b1, 1'b0);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc_ld = 1'b1; pc_din = 12'($urandom); exec_done = 1'b1;
      @(negedge clk);
      checks++; if (state !== 3'd0 || pc !== m_pc) begin
        errors++; $display("FAIL halt_idle state=%0d pc=%h exp 0/%h", state, pc, m_pc);
      end
    end
    halt = 1'b0; pc_ld = 1'b0; exec_done = 1'b0; start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    begin_run();
    mem_ready = 1'b0;
    @(negedge clk);
    checks++; if (state !== 3'd2 || mem_rd !== 1'b1) begin
      errors++; $display("FAIL pre_reset state=%0d rd=%b exp 2/1", state, mem_rd);
    end
    #2 clr_n = 1'b0;
    #1;
    checks++; if (mem_rd !== 0 || state !== 0 || pc !== 0 || ar !== 0 || ir !== 0 || ind !== 0 || sc !== 0 || t_dec !== 8'd1) begin
      errors++; $display("FAIL async_reset rd=%b state=%0d pc=%h ar=%h ir=%h ind=%b sc=%0d exp all zero", mem_rd, state, pc, ar, ir, ind, sc);
    end
    start = 1'b0;
    @(negedge clk); clr_n = 1'b1;
    m_pc = '0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int n;
    n = 20;
    begin_run();
    for (int k = 0; k < n; k++) begin
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(1, 5)),
                ($urandom_range(0, 3) == 0), 12'($urandom), 1'b0, (k == n - 1));
    end
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 16'($urandom);
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_indirect();
    test_branch();
    test_halt_start();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
